alu_addand_unit: RTL and testbench
==================================

Name: alu_addand_unit

Overview:
- Registered ALU slice for the 20-bit CPU datapath.
- Performs bitwise AND, add without carry-in, and add with carry-in on operands a and b.
- Supports full-word (20-bit) or half-word (low 10-bit) operation.
- Keeps a carry flag register, chained between add operations, and produces a registered zero flag.

Parameters:
- WIDTH, 20, full-word data width.
- HALF, 10, half-word width (WIDTH/2); half-word operations use bits [HALF-1:0].

Ports:
- clk    input   1      system clock, rising-edge active
- rst_n  input   1      asynchronous active-low reset
- en     input   1      operation strobe; operation is executed on a rising clk edge with en=1
- op     input   2      00=AND, 01=ADD without carry (add_wc), 10=ADD with carry (add_c), 11=reserved
- mode   input   1      1=full-word (20-bit), 0=half-word (low 10 bits)
- a      input   WIDTH  operand A
- b      input   WIDTH  operand B
- c      output  WIDTH  registered result
- zero   output  1      registered zero flag
- carry  output  1      registered carry flag; also the carry-in for add_c

Behaviour:
- Reset: rst_n=0 asynchronously forces c=0, zero=0, carry=0, independent of clk. The first active edge after rst_n rises executes normally.
- Latency: 1 cycle.
  - Inputs sampled on the rising edge with en=1.
  - c, zero and carry update on that same edge and are visible after it.
- en=0 or op=11: c, zero and carry hold their values (no-op).
- AND (op=00):
  - Full-word: c = a & b.
  - Half-word: c = {10'b0, a[9:0] & b[9:0]}.
  - carry unchanged.
- ADD without carry (op=01):
  - Full-word: {carry, c} = a + b (21-bit sum).
  - Half-word: {carry, c[9:0]} = a[9:0] + b[9:0]; c[19:10] = 0.
  - Incoming carry flag is ignored; carry is overwritten with the carry-out.
- ADD with carry (op=10):
  - Same as op=01 but adds the current carry flag as carry-in.
  - Full-word: {carry, c} = a + b + carry.
  - Half-word: {carry, c[9:0]} = a[9:0] + b[9:0] + carry; c[19:10] = 0.
- Carry-out bit: bit 20 of the sum in full-word mode; bit 10 in half-word mode.
- zero: set to 1 when the active-width result is all zeros (c[19:0] in full mode, c[9:0] in half mode), else 0. Updated on every executed op (00, 01, 10).
- Upper half of operands in half-word mode is ignored entirely; it never affects c, zero or carry.
- Wrap-around:
  - Overflow truncates to the active width.
  - Example: full-word 0xFFFFF+0x00001 gives c=0, carry=1, zero=1.
- Back-to-back add_c: each add_c uses the carry produced by the immediately preceding executed add (op 01/10). This supports multiword addition chains.
- Unsigned arithmetic throughout; no sign or overflow flag produced.
- Purely synchronous datapath apart from the async reset. No combinational path from inputs to outputs.

Test Plan:
1. Reset mid-operation: run ADD 0xFFFFF+0x00001 (carry=1), then assert rst_n=0 between edges -> c=0, zero=0, carry=0 immediately, without a clock edge.
2. AND full/half:
   - mode=1, a=0xF0F0F, b=0xFF00F -> c=0xF000F, zero=0, carry unchanged.
   - mode=0, a=0xABCFF, b=0x12300 -> c=0x00000, zero=1.
3. ADD without carry:
   - mode=1, a=0x12345, b=0x11111, carry preset to 1 -> c=0x23456, carry=0 (incoming carry ignored).
   - mode=0, a=0xFF3FF, b=0x00001 -> c=0x00000, carry=1, zero=1.
4. ADD with carry chain, mode=1:
   - op=01, a=0xFFFFF, b=0x00002 -> c=0x00001, carry=1.
   - Next cycle op=10, a=0x00010, b=0x00020 -> c=0x00031, carry=0.
5. Hold behaviour: en=0 or op=11 with arbitrary a/b -> c, zero, carry unchanged across several clocks.
6. Half-word add_c: carry=1, mode=0, a=0x801FF, b=0x40200 -> c=0x00000 (0x1FF+0x200+1=0x400, truncated), carry=1, zero=1.

Source files
------------

// File: rtl/alu_addand_unit.sv
// Registered ALU slice: AND, add, add-with-carry on full (WIDTH) or half (HALF) words.
// The result, zero and carry flags are all flops updated only on an executed operation.
module alu_addand_unit #(
  parameter int WIDTH = 20,
  parameter int HALF  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       op,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic             zero,
  output logic             carry
);

  localparam logic [1:0] OP_AND   = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_ADD_C = 2'b10;

  logic [WIDTH-1:0] c_q, c_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;

  logic [WIDTH-1:0] a_act, b_act, and_res, res;
  logic [WIDTH:0]   sum;
  logic             cin;
  logic             exec;

  always_comb begin
    // Half-word mode clears the upper operand bits so they can never leak into c, zero or carry.
    a_act   = mode ? a : {{(WIDTH-HALF){1'b0}}, a[HALF-1:0]};
    b_act   = mode ? b : {{(WIDTH-HALF){1'b0}}, b[HALF-1:0]};
    cin     = (op == OP_ADD_C) ? carry_q : 1'b0;
    and_res = a_act & b_act;
    sum     = {1'b0, a_act} + {1'b0, b_act} + {{WIDTH{1'b0}}, cin};
    exec    = en && (op != 2'b11);

    res     = and_res;
    c_d     = c_q;
    zero_d  = zero_q;
    carry_d = carry_q;

    if (op != OP_AND) begin
      res = mode ? sum[WIDTH-1:0] : {{(WIDTH-HALF){1'b0}}, sum[HALF-1:0]};
    end

    if (exec) begin
      c_d    = res;
      zero_d = (res == '0);
      if (op == OP_ADD || op == OP_ADD_C) begin
        carry_d = mode ? sum[WIDTH] : sum[HALF];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q     <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      c_q     <= c_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  assign c     = c_q;
  assign zero  = zero_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_alu_addand_unit.sv
// Directed bench for alu_addand_unit: hand-computed vectors for AND, add, add-with-carry,
// hold behaviour and asynchronous reset.
module tb_alu_addand_unit;

  localparam int WIDTH = 20;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [1:0]       op;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic             zero;
  logic             carry;

  int checks   = 0;
  int failures = 0;

  alu_addand_unit #(.WIDTH(20), .HALF(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .op    (op),
    .mode  (mode),
    .a     (a),
    .b     (b),
    .c     (c),
    .zero  (zero),
    .carry (carry)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [WIDTH-1:0] exp_c,
                           input logic exp_zero, input logic exp_carry);
    check_val({tag, ".c"},     32'(c),     32'(exp_c));
    check_val({tag, ".zero"},  32'(zero),  32'(exp_zero));
    check_val({tag, ".carry"}, 32'(carry), 32'(exp_carry));
  endtask

  // driver: present inputs on the falling edge, sample 1 time unit after the rising edge
  task automatic do_op(input logic [1:0] op_i, input logic mode_i,
                       input logic [WIDTH-1:0] a_i, input logic [WIDTH-1:0] b_i);
    @(negedge clk);
    en   = 1'b1;
    op   = op_i;
    mode = mode_i;
    a    = a_i;
    b    = b_i;
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    op    = 2'b00;
    mode  = 1'b1;
    a     = '0;
    b     = '0;
    #3;
    check_all("reset_state", 20'h00000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // asynchronous reset landing between clock edges
    do_op(2'b01, 1'b1, 20'hFFFFF, 20'h00001);
    check_all("add_wrap_full", 20'h00000, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_reset", 20'h00000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // AND full/half with carry preset to 1 to prove it is untouched
    do_op(2'b01, 1'b1, 20'hFFFFF, 20'h00001);
    check_all("carry_preset1", 20'h00000, 1'b1, 1'b1);
    do_op(2'b00, 1'b1, 20'hF0F0F, 20'hFF00F);
    check_all("and_full", 20'hF000F, 1'b0, 1'b1);
    do_op(2'b00, 1'b0, 20'hABCFF, 20'h12300);
    check_all("and_half", 20'h00000, 1'b1, 1'b1);

    // add without carry ignores the incoming carry flag
    do_op(2'b01, 1'b1, 20'h12345, 20'h11111);
    check_all("add_full", 20'h23456, 1'b0, 1'b0);
    do_op(2'b01, 1'b0, 20'hFF3FF, 20'h00001);
    check_all("add_half_wrap", 20'h00000, 1'b1, 1'b1);

    // multiword chain
    do_op(2'b01, 1'b1, 20'hFFFFF, 20'h00002);
    check_all("chain_lo", 20'h00001, 1'b0, 1'b1);
    do_op(2'b10, 1'b1, 20'h00010, 20'h00020);
    check_all("chain_hi", 20'h00031, 1'b0, 1'b0);

    // hold: en=0 for several clocks, then op=11 with en=1
    @(negedge clk);
    en   = 1'b0;
    op   = 2'b01;
    mode = 1'b1;
    a    = 20'hFFFFF;
    b    = 20'hFFFFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_all("hold_en0", 20'h00031, 1'b0, 1'b0);
    end
    @(negedge clk);
    en = 1'b1;
    op = 2'b11;
    a  = 20'h00000;
    b  = 20'h00000;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_all("hold_op11", 20'h00031, 1'b0, 1'b0);
    end
    en = 1'b0;

    // half-word add_c with carry-in 1 and noisy upper operand bits
    do_op(2'b01, 1'b1, 20'hFFFFF, 20'h00001);
    check_all("carry_preset2", 20'h00000, 1'b1, 1'b1);
    do_op(2'b10, 1'b0, 20'h801FF, 20'h40200);
    check_all("addc_half_wrap", 20'h00000, 1'b1, 1'b1);

    // add_c with carry-in 1, no carry-out, full word
    do_op(2'b10, 1'b1, 20'h7FFFF, 20'h00000);
    check_all("addc_full_cin", 20'h80000, 1'b0, 1'b0);
    // add_c with carry-in 0 leaves the sum unchanged
    do_op(2'b10, 1'b0, 20'hFFC05, 20'h00003);
    check_all("addc_half_cin0", 20'h00008, 1'b0, 1'b0);
    // full-word add_c producing a carry out of bit 19
    do_op(2'b10, 1'b1, 20'h80000, 20'h80001);
    check_all("addc_full_cout", 20'h00001, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
